// File: rtl/clk_divider_multi_if.sv
// Configuration channel for clk_divider_multi: valid/ready handshake carrying
// the target channel, the new terminal count and the output mode.
interface clk_divider_multi_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 24
) ();
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel clock-enable divider. Every channel counts prescaler strobes
// up to its terminal count, emits a one-clk tick and drives clk_LF either as
// a 50% square wave (mode 0) or as a copy of tick (mode 1). New divisor/mode
// values are staged in a shadow register and take effect at the channel's
// next terminal count (or immediately while the channel is disabled).
// Optional feature macro: CLK_DIVIDER_MULTI_PRESCALE_EN enables the
// 2^PRE_LOG2 prescaler; without it every clk is a strobe.
module clk_divider_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CW       = 24,
  parameter int unsigned PRE_LOG2 = 3,
  parameter int unsigned DIV_INIT = 320000
) (
  input  logic                  clk,
  input  logic                  btnC,
  input  logic [NCH-1:0]        en,
  clk_divider_multi_if.slave    cfg,
  output logic [NCH-1:0]        clk_LF,
  output logic [NCH-1:0]        tick
);

  logic           pre_stb;
  logic [CW-1:0]  cnt    [NCH];
  logic [CW-1:0]  cnt_n  [NCH];
  logic [CW-1:0]  div_q  [NCH];
  logic [CW-1:0]  div_n  [NCH];
  logic [CW-1:0]  sdiv_q [NCH];
  logic [CW-1:0]  sdiv_n [NCH];
  logic [NCH-1:0] mode_q, mode_n;
  logic [NCH-1:0] smode_q, smode_n;
  logic [NCH-1:0] pend_q, pend_n;
  logic [NCH-1:0] lf_n, tick_n;
  logic [NCH-1:0] apply;
  logic           rdy_q;
  logic           ch_ok;
  logic           accept;

`ifdef CLK_DIVIDER_MULTI_PRESCALE_EN
  logic [PRE_LOG2-1:0] pre_cnt;

  // Free-running prescaler; strobe while it sits at all-ones
  always_ff @(posedge clk) begin
    if (!btnC) pre_cnt <= '0;
    else       pre_cnt <= pre_cnt + PRE_LOG2'(1);
  end

  assign pre_stb = &pre_cnt;
`else
  // PRE_LOG2 has no effect without the prescaler
  logic unused_pre_log2;
  assign unused_pre_log2 = ^PRE_LOG2;
  assign pre_stb = 1'b1;
`endif

  // Out-of-range channel numbers are always accepted and then dropped
  assign ch_ok         = 32'(cfg.cfg_ch) < NCH;
  assign cfg.cfg_ready = rdy_q & (~ch_ok | ~pend_q[cfg.cfg_ch]);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready & ch_ok;

  // Per-channel counting, output shaping, shadow apply and config capture.
  // An apply needs pend_q=1 while an accept needs pend_q=0, so a config
  // accepted on a terminal-count cycle waits for the following terminal count.
  always_comb begin
    cnt_n   = cnt;
    div_n   = div_q;
    sdiv_n  = sdiv_q;
    mode_n  = mode_q;
    smode_n = smode_q;
    pend_n  = pend_q;
    lf_n    = clk_LF;
    tick_n  = '0;
    apply   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!en[i]) begin
        cnt_n[i] = '0;
        lf_n[i]  = 1'b0;
        apply[i] = pend_q[i];
      end else if (pre_stb && (cnt[i] == div_q[i])) begin
        cnt_n[i]  = '0;
        tick_n[i] = 1'b1;
        lf_n[i]   = mode_q[i] ? 1'b1 : ~clk_LF[i];
        apply[i]  = pend_q[i];
      end else begin
        if (pre_stb) cnt_n[i] = cnt[i] + CW'(1);
        if (mode_q[i]) lf_n[i] = 1'b0;
      end
      if (apply[i]) begin
        div_n[i]  = sdiv_q[i];
        mode_n[i] = smode_q[i];
        pend_n[i] = 1'b0;
        if (smode_q[i] != mode_q[i]) lf_n[i] = 1'b0;
      end
    end
    if (accept) begin
      sdiv_n[cfg.cfg_ch]  = cfg.cfg_div;
      smode_n[cfg.cfg_ch] = cfg.cfg_mode;
      pend_n[cfg.cfg_ch]  = 1'b1;
    end
  end

  // State and output registers; reset discards any staged configuration
  always_ff @(posedge clk) begin
    if (!btnC) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        div_q[i]  <= CW'(DIV_INIT);
        sdiv_q[i] <= '0;
      end
      mode_q  <= '0;
      smode_q <= '0;
      pend_q  <= '0;
      clk_LF  <= '0;
      tick    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_q   <= div_n;
      sdiv_q  <= sdiv_n;
      mode_q  <= mode_n;
      smode_q <= smode_n;
      pend_q  <= pend_n;
      clk_LF  <= lf_n;
      tick    <= tick_n;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Randomized bench for clk_divider_multi. The reference model tracks, per
// channel, the absolute clk index of the next expected tick, derived from the
// prescaler strobe grid and (div+1) strobes per period.
module tb_clk_divider_multi;
  localparam int unsigned NCH      = 3;
  localparam int unsigned CW       = 8;
  localparam int unsigned PRE_LOG2 = 3;
  localparam int unsigned DIV_INIT = 4;
`ifdef CLK_DIVIDER_MULTI_PRESCALE_EN
  localparam int P = 1 << PRE_LOG2;
`else
  localparam int P = 1;
`endif

  logic           clk = 1'b0;
  logic           btnC;
  logic [NCH-1:0] en;
  logic [NCH-1:0] clk_LF;
  logic [NCH-1:0] tick;

  clk_divider_multi_if #(.NCH(NCH), .CW(CW)) cfg_if ();

  clk_divider_multi #(
    .NCH(NCH), .CW(CW), .PRE_LOG2(PRE_LOG2), .DIV_INIT(DIV_INIT)
  ) dut (
    .clk(clk), .btnC(btnC), .en(en), .cfg(cfg_if.slave),
    .clk_LF(clk_LF), .tick(tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  int     e;
  bit     rdy_ok;
  int     m_div   [NCH];
  int     m_sdiv  [NCH];
  bit     m_mode  [NCH];
  bit     m_smode [NCH];
  bit     m_pend  [NCH];
  bit     m_lf    [NCH];
  bit     m_tk    [NCH];
  bit     m_armed [NCH];
  longint m_due   [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_ready(input int ch);
    if (!rdy_ok) return 1'b0;
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic longint first_strobe(input longint t);
    return t + ((P - 1) - (t % P));
  endfunction

  task automatic m_apply(input int i);
    if (m_smode[i] != m_mode[i]) m_lf[i] = 1'b0;
    m_div[i]  = m_sdiv[i];
    m_mode[i] = m_smode[i];
    m_pend[i] = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs stable before it
  task automatic model_edge();
    bit acc;
    int ach;
    if (!btnC) begin
      e = 0;
      rdy_ok = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = DIV_INIT; m_mode[i] = 1'b0; m_pend[i] = 1'b0;
        m_lf[i] = 1'b0; m_tk[i] = 1'b0; m_armed[i] = 1'b0;
      end
      return;
    end
    ach = int'(cfg_if.cfg_ch);
    acc = cfg_if.cfg_valid && m_ready(ach);
    for (int i = 0; i < NCH; i++) begin
      m_tk[i] = 1'b0;
      if (!en[i]) begin
        m_lf[i] = 1'b0;
        m_armed[i] = 1'b0;
        if (m_pend[i]) m_apply(i);
      end else begin
        if (!m_armed[i]) begin
          m_armed[i] = 1'b1;
          m_due[i] = first_strobe(e) + longint'(m_div[i]) * P;
        end
        if (longint'(e) == m_due[i]) begin
          m_tk[i] = 1'b1;
          m_lf[i] = m_mode[i] ? 1'b1 : !m_lf[i];
          if (m_pend[i]) m_apply(i);
          m_due[i] = e + longint'(m_div[i] + 1) * P;
        end else if (m_mode[i]) begin
          m_lf[i] = 1'b0;
        end
      end
    end
    if (acc && ach < NCH) begin
      m_sdiv[ach]  = int'(cfg_if.cfg_div);
      m_smode[ach] = cfg_if.cfg_mode;
      m_pend[ach]  = 1'b1;
    end
    rdy_ok = 1'b1;
    e++;
  endtask

  task automatic compare();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tk[i]));
      check($sformatf("clk_LF%0d", i), 32'(clk_LF[i]), 32'(m_lf[i]));
    end
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready(int'(cfg_if.cfg_ch))));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic send_cfg(input int ch, input int dv, input bit md);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch[1:0];
    cfg_if.cfg_div   = dv[CW-1:0];
    cfg_if.cfg_mode  = md;
    cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    btnC = 1'b0;
    en = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_div = '0;
    cfg_if.cfg_mode = 1'b0;
    @(negedge clk);
    repeat (3) cycle();

    // Default divisor, all channels running
    btnC = 1'b1;
    en = '1;
    repeat (4 * (DIV_INIT + 1) * P) cycle();

    // Channel 0 to pulse mode with div 0 while running; ch1 then double-configured
    send_cfg(0, 0, 1'b1);
    send_cfg(1, 2, 1'b0);
    send_cfg(1, 6, 1'b1);
    send_cfg(3, 1, 1'b1);
    repeat (3 * (DIV_INIT + 1) * P) cycle();

    // Channel disable / re-enable
    en[0] = 1'b0;
    repeat (5) cycle();
    en[0] = 1'b1;
    repeat (2 * (DIV_INIT + 1) * P) cycle();

    // Reset while a config is pending
    send_cfg(2, 1, 1'b1);
    btnC = 1'b0;
    repeat (3) cycle();
    btnC = 1'b1;
    repeat (2 * (DIV_INIT + 1) * P) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_if.cfg_valid = ($urandom % 5) == 0;
      cfg_if.cfg_ch    = 2'($urandom % 4);
      cfg_if.cfg_div   = CW'($urandom % 8);
      cfg_if.cfg_mode  = 1'($urandom % 2);
      for (int i = 0; i < NCH; i++)
        if (($urandom % 40) == 0) en[i] = ~en[i];
      if (($urandom % 400) == 0) btnC = 1'b0;
      else if (!btnC && ($urandom % 3) == 0) btnC = 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
